// File: rtl/processor_pkg.sv
// Shared pipeline definitions: memory-op encodings, static-field layout,
// default widths and the memory-stage FSM state type.
package processor_pkg;

  localparam int OPERAND_SIZE_DEF     = 32;
  localparam int REG_ADDRESS_SIZE_DEF = 5;

  // Static field: bit [REG_ADDRESS_SIZE] is the register write enable
  localparam int REG_WE_BIT = REG_ADDRESS_SIZE_DEF;

  localparam logic [1:0] MEM_OP_PASS  = 2'b00;
  localparam logic [1:0] MEM_OP_LOAD  = 2'b01;
  localparam logic [1:0] MEM_OP_STORE = 2'b10;

  typedef enum logic {
    MEM_IDLE   = 1'b0,
    MEM_ACCESS = 1'b1
  } mem_state_e;

  // True for ops that touch data memory; the reserved code behaves as pass
  function automatic logic is_mem_op(input logic [1:0] op);
    return (op == MEM_OP_LOAD) || (op == MEM_OP_STORE);
  endfunction

endpackage

// File: rtl/wb_latch.sv
// Registered writeback record. Valid and misaligned are single-cycle pulses;
// the remaining fields hold their last value between pulses.
module wb_latch #(
  parameter int OPERAND_SIZE     = 32,
  parameter int REG_ADDRESS_SIZE = 5
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        i_load,
  input  logic                        i_we,
  input  logic [REG_ADDRESS_SIZE-1:0] i_reg,
  input  logic [OPERAND_SIZE-1:0]     i_data,
  input  logic                        i_misaligned,
  output logic                        o_valid,
  output logic                        o_we,
  output logic [REG_ADDRESS_SIZE-1:0] o_reg,
  output logic [OPERAND_SIZE-1:0]     o_data,
  output logic                        o_misaligned
);

  // Capture a new record on i_load, otherwise drop the pulses and hold fields
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_valid      <= 1'b0;
      o_we         <= 1'b0;
      o_reg        <= '0;
      o_data       <= '0;
      o_misaligned <= 1'b0;
    end else if (i_load) begin
      o_valid      <= 1'b1;
      o_we         <= i_we;
      o_reg        <= i_reg;
      o_data       <= i_data;
      o_misaligned <= i_misaligned;
    end else begin
      o_valid      <= 1'b0;
      o_misaligned <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: pass-through, or one load/store per
// instruction over a req/ready handshake, with a registered writeback record.
//
// Handshake: DM_req is high for every cycle the FSM is in ACCESS; DM_we,
// DM_addr and DM_wdata are held from capture registers and stay stable until
// the cycle in which DM_ready is sampled 1, which completes the access.
// DM_ready is ignored while DM_req is low. Upstream sees MEM_stall_out for
// exactly the same cycles as DM_req and must hold its outputs.
module mem_stage
  import processor_pkg::*;
#(
  parameter int OPERAND_SIZE     = OPERAND_SIZE_DEF,
  parameter int REG_ADDRESS_SIZE = REG_ADDRESS_SIZE_DEF
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        MEM_valid_in,
  input  logic                        MEM_flush,
  input  logic [1:0]                  MEM_op,
  input  logic [OPERAND_SIZE-1:0]     MEM_address,
  input  logic [OPERAND_SIZE-1:0]     MEM_store_data,
  input  logic [REG_ADDRESS_SIZE:0]   MEM_static_in,
  output logic                        MEM_stall_out,
  output logic                        DM_req,
  output logic                        DM_we,
  output logic [OPERAND_SIZE-1:0]     DM_addr,
  output logic [OPERAND_SIZE-1:0]     DM_wdata,
  input  logic [OPERAND_SIZE-1:0]     DM_rdata,
  input  logic                        DM_ready,
  output logic                        WB_valid,
  output logic                        WB_we,
  output logic [REG_ADDRESS_SIZE-1:0] WB_reg,
  output logic [OPERAND_SIZE-1:0]     WB_data,
  output logic                        MEM_misaligned,
  output logic                        MEM_dbg_state
);

  mem_state_e                  r_state;
  logic [OPERAND_SIZE-1:0]     r_addr;
  logic [OPERAND_SIZE-1:0]     r_wdata;
  logic                        r_is_store;
  logic                        r_we;
  logic [REG_ADDRESS_SIZE-1:0] r_reg;
  logic                        r_kill;

  logic                        w_accept;
  logic                        w_is_mem;
  logic                        w_misaligned;
  logic                        w_start;
  logic                        w_wb_fire;
  logic                        w_wb_we;
  logic [REG_ADDRESS_SIZE-1:0] w_wb_reg;
  logic [OPERAND_SIZE-1:0]     w_wb_data;
  logic                        w_wb_mis;

  assign w_accept     = (r_state == MEM_IDLE) && MEM_valid_in && !MEM_flush;
  assign w_is_mem     = is_mem_op(MEM_op);
  assign w_misaligned = (MEM_address[1:0] != 2'b00);
  assign w_start      = w_accept && w_is_mem && !w_misaligned;

  // Memory-side outputs come straight from state so reset drops them at once
  assign MEM_stall_out = (r_state == MEM_ACCESS);
  assign DM_req        = (r_state == MEM_ACCESS);
  assign DM_we         = (r_state == MEM_ACCESS) && r_is_store;
  assign DM_addr       = r_addr;
  assign DM_wdata      = r_wdata;
  assign MEM_dbg_state = r_state;

  // FSM: capture aligned load/store in IDLE, wait for DM_ready in ACCESS
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= MEM_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_is_store <= 1'b0;
      r_we       <= 1'b0;
      r_reg      <= '0;
      r_kill     <= 1'b0;
    end else begin
      case (r_state)
        MEM_IDLE: begin
          if (w_start) begin
            r_addr     <= MEM_address;
            r_wdata    <= MEM_store_data;
            r_is_store <= (MEM_op == MEM_OP_STORE);
            r_we       <= MEM_static_in[REG_ADDRESS_SIZE];
            r_reg      <= MEM_static_in[REG_ADDRESS_SIZE-1:0];
            r_kill     <= 1'b0;
            r_state    <= MEM_ACCESS;
          end
        end
        MEM_ACCESS: begin
          if (DM_ready) begin
            r_kill  <= 1'b0;
            r_state <= MEM_IDLE;
          end else if (MEM_flush) begin
            r_kill  <= 1'b1;
          end
        end
        default: r_state <= MEM_IDLE;
      endcase
    end
  end

  // Next writeback record; a flush in the completing cycle also kills it
  always_comb begin
    w_wb_fire = 1'b0;
    w_wb_we   = 1'b0;
    w_wb_reg  = MEM_static_in[REG_ADDRESS_SIZE-1:0];
    w_wb_data = '0;
    w_wb_mis  = 1'b0;
    if (r_state == MEM_ACCESS) begin
      w_wb_reg = r_reg;
      if (DM_ready && !r_kill && !MEM_flush) begin
        w_wb_fire = 1'b1;
        w_wb_we   = r_we && !r_is_store;
        w_wb_data = r_is_store ? '0 : DM_rdata;
      end
    end else if (w_accept) begin
      if (!w_is_mem) begin
        w_wb_fire = 1'b1;
        w_wb_we   = MEM_static_in[REG_ADDRESS_SIZE];
        w_wb_data = MEM_address;
      end else if (w_misaligned) begin
        w_wb_fire = 1'b1;
        w_wb_mis  = 1'b1;
      end
    end
  end

  wb_latch #(
    .OPERAND_SIZE     (OPERAND_SIZE),
    .REG_ADDRESS_SIZE (REG_ADDRESS_SIZE)
  ) u_wb_latch (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_load       (w_wb_fire),
    .i_we         (w_wb_we),
    .i_reg        (w_wb_reg),
    .i_data       (w_wb_data),
    .i_misaligned (w_wb_mis),
    .o_valid      (WB_valid),
    .o_we         (WB_we),
    .o_reg        (WB_reg),
    .o_data       (WB_data),
    .o_misaligned (MEM_misaligned)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table of single-cycle instructions
// plus hand-written multi-cycle sequences for memory accesses, flush and reset.
module tb_mem_stage;

  logic        clk;
  logic        reset_n;
  logic        MEM_valid_in;
  logic        MEM_flush;
  logic [1:0]  MEM_op;
  logic [31:0] MEM_address;
  logic [31:0] MEM_store_data;
  logic [5:0]  MEM_static_in;
  logic        MEM_stall_out;
  logic        DM_req;
  logic        DM_we;
  logic [31:0] DM_addr;
  logic [31:0] DM_wdata;
  logic [31:0] DM_rdata;
  logic        DM_ready;
  logic        WB_valid;
  logic        WB_we;
  logic [4:0]  WB_reg;
  logic [31:0] WB_data;
  logic        MEM_misaligned;
  logic        MEM_dbg_state;

  int n_vec;
  int n_fail;

  mem_stage dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .MEM_valid_in   (MEM_valid_in),
    .MEM_flush      (MEM_flush),
    .MEM_op         (MEM_op),
    .MEM_address    (MEM_address),
    .MEM_store_data (MEM_store_data),
    .MEM_static_in  (MEM_static_in),
    .MEM_stall_out  (MEM_stall_out),
    .DM_req         (DM_req),
    .DM_we          (DM_we),
    .DM_addr        (DM_addr),
    .DM_wdata       (DM_wdata),
    .DM_rdata       (DM_rdata),
    .DM_ready       (DM_ready),
    .WB_valid       (WB_valid),
    .WB_we          (WB_we),
    .WB_reg         (WB_reg),
    .WB_data        (WB_data),
    .MEM_misaligned (MEM_misaligned),
    .MEM_dbg_state  (MEM_dbg_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  typedef struct {
    logic        valid;
    logic        flush;
    logic [1:0]  op;
    logic [31:0] addr;
    logic [5:0]  st;
    logic        e_valid;
    logic        e_we;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
    logic        e_mis;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic f, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] sd, input logic [5:0] st);
    MEM_valid_in   = v;
    MEM_flush      = f;
    MEM_op         = op;
    MEM_address    = a;
    MEM_store_data = sd;
    MEM_static_in  = st;
  endtask

  // One aligned load/store; memory answers in the k-th cycle of the access
  task automatic mem_access(input logic [1:0] op, input logic [31:0] a, input logic [31:0] sd,
                            input logic [5:0] st, input int k, input logic [31:0] rdata,
                            input logic e_we, input logic [31:0] e_data);
    int stall_cnt;
    @(negedge clk);
    drive(1'b1, 1'b0, op, a, sd, st);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 6'h0);
    chk("acc_req", DM_req, 1);
    chk("acc_dm_we", DM_we, op == 2'b10);
    if (op == 2'b10) chk("acc_wdata", DM_wdata, sd);
    stall_cnt = 0;
    for (int i = 1; i <= k; i++) begin
      if (MEM_stall_out) stall_cnt++;
      chk("acc_addr_stable", DM_addr, a);
      chk("acc_wb_quiet", WB_valid, 0);
      if (i == k) begin
        DM_ready = 1'b1;
        DM_rdata = rdata;
      end
      @(posedge clk); #1;
      DM_ready = 1'b0;
    end
    chk("acc_stall_cycles", stall_cnt, k);
    chk("acc_stall_drop", MEM_stall_out, 0);
    chk("acc_req_drop", DM_req, 0);
    chk("acc_wb_valid", WB_valid, 1);
    chk("acc_wb_we", WB_we, e_we);
    chk("acc_wb_reg", WB_reg, st[4:0]);
    chk("acc_wb_data", WB_data, e_data);
    chk("acc_wb_mis", MEM_misaligned, 0);
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    reset_n  = 1'b0;
    DM_ready = 1'b0;
    DM_rdata = 32'h0;
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 6'h0);

    //                valid flush op    addr          static      ev we reg    data          mis
    vecs[0] = '{1'b1, 1'b0, 2'b00, 32'h0000_0042, 6'b1_00011, 1, 1, 5'd3,  32'h0000_0042, 0};
    vecs[1] = '{1'b0, 1'b0, 2'b00, 32'h0000_0099, 6'b1_01001, 0, 1, 5'd3,  32'h0000_0042, 0};
    vecs[2] = '{1'b1, 1'b0, 2'b11, 32'h0000_1234, 6'b0_01010, 1, 0, 5'd10, 32'h0000_1234, 0};
    vecs[3] = '{1'b1, 1'b0, 2'b01, 32'h0000_0102, 6'b1_00111, 1, 0, 5'd7,  32'h0000_0000, 1};
    vecs[4] = '{1'b1, 1'b1, 2'b00, 32'h0000_0055, 6'b1_00001, 0, 0, 5'd7,  32'h0000_0000, 0};
    vecs[5] = '{1'b1, 1'b0, 2'b10, 32'h0000_0203, 6'b1_00010, 1, 0, 5'd2,  32'h0000_0000, 1};
    vecs[6] = '{1'b1, 1'b0, 2'b00, 32'hFFFF_FFFF, 6'b1_11111, 1, 1, 5'd31, 32'hFFFF_FFFF, 0};
    vecs[7] = '{1'b1, 1'b0, 2'b00, 32'h0000_0000, 6'b0_00000, 1, 0, 5'd0,  32'h0000_0000, 0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_wb_valid", WB_valid, 0);
    chk("rst_wb_data", WB_data, 0);
    chk("rst_wb_reg", WB_reg, 0);
    chk("rst_req", DM_req, 0);
    chk("rst_stall", MEM_stall_out, 0);
    chk("rst_mis", MEM_misaligned, 0);
    chk("rst_state", MEM_dbg_state, 0);
    reset_n = 1'b1;

    // Single-cycle instructions, back to back
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].flush, vecs[i].op, vecs[i].addr, 32'hA5A5_0000, vecs[i].st);
      chk("vec_stall_pre", MEM_stall_out, 0);
      @(posedge clk); #1;
      chk("vec_wb_valid", WB_valid, vecs[i].e_valid);
      chk("vec_wb_we", WB_we, vecs[i].e_we);
      chk("vec_wb_reg", WB_reg, vecs[i].e_reg);
      chk("vec_wb_data", WB_data, vecs[i].e_data);
      chk("vec_mis", MEM_misaligned, vecs[i].e_mis);
      chk("vec_req", DM_req, 0);
      chk("vec_stall", MEM_stall_out, 0);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 6'h0);

    // Load with 3-cycle memory latency, then a store with zero wait
    mem_access(2'b01, 32'h0000_0100, 32'h0, 6'b1_00101, 3, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF);
    mem_access(2'b10, 32'h0000_0204, 32'h0000_1234, 6'b1_00001, 1, 32'h0BAD_0BAD, 1'b0, 32'h0);
    @(posedge clk); #1;
    chk("wb_pulse_ends", WB_valid, 0);
    chk("wb_hold_reg", WB_reg, 5'd1);

    // Flush during a 2-cycle load: access completes silently, next pass goes at once
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b01, 32'h0000_0300, 32'h0, 6'b1_01000);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 6'h0);
    chk("fl_req", DM_req, 1);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 2'b00, 32'h0000_0077, 32'h0, 6'b1_00100);
    DM_ready = 1'b1;
    DM_rdata = 32'h1111_2222;
    chk("fl_stall", MEM_stall_out, 1);
    @(posedge clk); #1;
    DM_ready = 1'b0;
    chk("fl_no_wb", WB_valid, 0);
    chk("fl_idle", MEM_stall_out, 0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 6'h0);
    chk("fl_pass_valid", WB_valid, 1);
    chk("fl_pass_data", WB_data, 32'h0000_0077);
    chk("fl_pass_reg", WB_reg, 5'd4);
    chk("fl_pass_we", WB_we, 1);

    // DM_ready while idle is ignored
    DM_ready = 1'b1;
    @(posedge clk); #1;
    DM_ready = 1'b0;
    chk("idle_ready_wb", WB_valid, 0);
    chk("idle_ready_state", MEM_dbg_state, 0);

    // Reset in ACCESS
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b01, 32'h0000_0400, 32'h0, 6'b1_00110);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 6'h0);
    chk("rr_req_before", DM_req, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("rr_req", DM_req, 0);
    chk("rr_stall", MEM_stall_out, 0);
    chk("rr_wb_valid", WB_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rr_state_idle", MEM_dbg_state, 0);
    chk("rr_req_after", DM_req, 0);
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b00, 32'h0000_0ABC, 32'h0, 6'b1_01100);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 6'h0);
    chk("rr_pass_valid", WB_valid, 1);
    chk("rr_pass_data", WB_data, 32'h0000_0ABC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the pipeline, directly downstream of the ALU stage. It consumes the ALU result (as address or pass-through value) together with the static destination-register field. It performs at most one data-memory load or store per instruction over a request/ready handshake and stalls the upstream pipeline while an access is outstanding. It delivers one registered writeback record per instruction to the register file.

## Interface
- OPERAND_SIZE, 32, datapath and memory word width
- REG_ADDRESS_SIZE, 5, register-file address width
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- MEM_valid_in  in  1  ALU stage presents a valid instruction
- MEM_flush  in  1  discard the current/incoming instruction (branch squash)
- MEM_op  in  2  00 pass, 01 load, 10 store, 11 reserved (behaves as pass)
- MEM_address  in  OPERAND_SIZE  ALU result; the address for load/store, the writeback data for pass
- MEM_store_data  in  OPERAND_SIZE  store data
- MEM_static_in  in  REG_ADDRESS_SIZE+1  bit [REG_ADDRESS_SIZE] = register write enable, bits below = destination register
- MEM_stall_out  out  1  upstream must hold its outputs
- DM_req  out  1  memory request
- DM_we  out  1  1 = store
- DM_addr  out  OPERAND_SIZE  word address
- DM_wdata  out  OPERAND_SIZE  store data
- DM_rdata  in  OPERAND_SIZE  load data, valid when DM_ready=1
- DM_ready  in  1  access completes in this cycle
- WB_valid  out  1  one-cycle pulse per retired instruction
- WB_we  out  1  register write enable
- WB_reg  out  REG_ADDRESS_SIZE  destination register
- WB_data  out  OPERAND_SIZE  writeback value
- MEM_misaligned  out  1  one-cycle pulse, aligned with WB_valid, on a misaligned load/store

## Operation
- FSM with states IDLE and ACCESS. Reset enters IDLE, and every output is 0.
- IDLE, MEM_valid_in=1, MEM_flush=0:
  - Pass/reserved: next edge WB_valid=1, WB_data=MEM_address, WB_we/WB_reg from MEM_static_in.
  - Load/store with MEM_address[1:0]≠0: no memory access. Next edge WB_valid=1, WB_we=0, MEM_misaligned=1.
  - Aligned load/store: capture address, data, op and static field, then go to ACCESS.
- IDLE with MEM_valid_in=0 or MEM_flush=1: nothing captured; WB_valid=0 next cycle.
- ACCESS:
  - DM_req=1; DM_we/DM_addr/DM_wdata come from the captured registers and stay stable until DM_ready is sampled 1.
  - MEM_stall_out=1; MEM_valid_in is ignored.
- ACCESS with DM_ready=1: return to IDLE. Next edge WB_valid=1 with:
  - load: WB_data=DM_rdata, WB_we=captured enable
  - store: WB_we=0, WB_data=0
- MEM_flush in ACCESS sets a kill flag. The access still completes (memory cannot be aborted), but WB_valid stays 0 for it. The flag clears on return to IDLE.
- MEM_stall_out is combinational: state==ACCESS.
- Asserting reset_n=0 mid-access drops DM_req immediately and discards the instruction.

## Timing
- Pass latency: 1 cycle, accepted at edge N, WB_valid during cycle N+1. Throughput is 1 per cycle.
- Load/store latency:
  - accepted at edge N; DM_req high from cycle N+1
  - DM_ready high in cycle N+k (k≥1); WB_valid during cycle N+k+1
  - MEM_stall_out high in cycles N+1…N+k
  - next instruction accepted at edge N+k+1 (zero-wait: 2 cycles per access)
- WB outputs are registered. Between pulses, WB_valid=0 and the other WB fields hold their last value.
- DM_ready while DM_req=0 is ignored.

## Structure
- Shared package processor_pkg:
  - MEM_OP_PASS/LOAD/STORE encodings
  - static-field bit index REG_WE_BIT=REG_ADDRESS_SIZE
  - OPERAND_SIZE/REG_ADDRESS_SIZE defaults, shared with the ALU stage
- One sub-module, wb_latch: the registered writeback record (valid, we, reg, data, misaligned) with asynchronous active-low reset.

## Test plan
- Reset, then a pass with MEM_address=0x0000_0042 and static=6'b1_00011 → next cycle WB_valid=1, WB_reg=3, WB_we=1, WB_data=0x42; MEM_stall_out never rises.
- Load from 0x100 with static=6'b1_00101; memory gives DM_ready after 3 cycles with rdata=0xDEADBEEF → stall high 3 cycles, DM_addr=0x100 stable throughout, then WB_data=0xDEADBEEF, WB_reg=5.
- Store of 0x1234 to 0x204 with write-enable bit set → DM_we=1, DM_wdata=0x1234; retires with WB_valid=1, WB_we=0.
- Load from 0x102 → no DM_req; WB_valid=1, WB_we=0, MEM_misaligned=1.
- Flush asserted during a 2-cycle load → access completes, no WB_valid pulse; a following pass is accepted on the very next edge.
- reset_n pulsed low in ACCESS → DM_req, MEM_stall_out and WB_valid all go 0 immediately; FSM is in IDLE after release.
